// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle multiply/divide engine with HI/LO result registers.
// Signed and unsigned multiply use shift-add. Signed and unsigned divide use
// restoring division on operand magnitudes, with the signs applied in FIX.
// Optional feature macro: MULDIV_MADD_EN enables MADD/MADDU accumulation into
// {hi,lo} when op[2]=1 on a multiply.
`timescale 1ns/1ps

module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_w,
    input  logic             lo_w,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              q_neg_q, q_neg_d;     // product / quotient is negative
    logic              r_neg_q, r_neg_d;     // remainder takes the dividend's sign
    logic [WIDTH-1:0]  opnd_q, opnd_d;       // multiplicand or divisor magnitude
    logic [WIDTH:0]    rem_q, rem_d;         // upper working half
    logic [WIDTH-1:0]  quo_q, quo_d;         // lower working half (multiplier / quotient)
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;
`ifdef MULDIV_MADD_EN
    logic              acc_q, acc_d;
`else
    logic              unused_op2;
    assign unused_op2 = op[2];
`endif

    // Datapath step and result terms
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_shift;
    logic [WIDTH:0]      div_diff;
    logic                div_ok;
    logic [2*WIDTH-1:0]  product;
    logic [2*WIDTH-1:0]  prod_res;
    logic [WIDTH-1:0]    quot_res;
    logic [WIDTH-1:0]    rem_res;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    // Iteration arithmetic and sign-corrected final results
    always_comb begin
        mul_sum   = rem_q + (quo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
        product   = {rem_q[WIDTH-1:0], quo_q};
        prod_res  = q_neg_q ? -product : product;
`ifdef MULDIV_MADD_EN
        if (acc_q) begin
            prod_res = prod_res + {hi_q, lo_q};
        end
`endif
        quot_res  = q_neg_q ? -quo_q : quo_q;
        rem_res   = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    // Next-state, operand capture, iteration and result write-back
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        opnd_d   = opnd_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
`ifdef MULDIV_MADD_EN
        acc_d    = acc_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (hi_w) hi_d = wdata;
                if (lo_w) lo_d = wdata;
                if (start && !cancel) begin
                    if (op[1] && (b == '0)) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        is_div_d = op[1];
                        q_neg_d  = !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_d  = !op[0] && op[1] && a[WIDTH-1];
                        opnd_d   = op[1] ? mag(b, !op[0]) : mag(a, !op[0]);
                        quo_d    = op[1] ? mag(a, !op[0]) : mag(b, !op[0]);
                        rem_d    = '0;
                        cnt_d    = '0;
`ifdef MULDIV_MADD_EN
                        acc_d    = op[2] && !op[1];
`endif
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        rem_d = div_ok ? div_diff : div_shift;
                        quo_d = {quo_q[WIDTH-2:0], div_ok};
                    end else begin
                        rem_d = {1'b0, mul_sum[WIDTH:1]};
                        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quot_res;
                    end else begin
                        {hi_d, lo_d} = prod_res;
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            opnd_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_q    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            opnd_q   <= opnd_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
`ifdef MULDIV_MADD_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit at WIDTH=32. Expected HI/LO results are queued
// when an operation is launched and compared when done is observed.
// Build with MULDIV_MADD_EN defined to exercise the accumulate variant.
`timescale 1ns/1ps

module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cancel = 1'b0;
    logic         hi_w = 1'b0;
    logic         lo_w = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .hi_w     (hi_w),
        .lo_w     (lo_w),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one start at a negedge, queue its expectation; returns at the negedge after edge 0.
    task automatic launch(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edz);
        exp_t e;
        e.tag = tag; e.hi = ehi; e.lo = elo; e.dz = edz;
        sb.push_back(e);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
    endtask

    // Wait (bounded) for done, pop the scoreboard and check results and timing.
    task automatic wait_done(input bit b2b);
        exp_t e;
        int k = 0;
        int busy_n = 0;
        while (done !== 1'b1 && k < 100) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            k++;
        end
        e.tag = "sb_empty"; e.hi = 'x; e.lo = 'x; e.dz = 1'b0;
        if (sb.size() > 0) e = sb.pop_front();
        check({e.tag, "_done_seen"}, 64'(done), 64'(1));
        check({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
        check({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
        check({e.tag, "_div_zero"}, 64'(div_zero), 64'(e.dz));
        check({e.tag, "_latency"}, 64'(k), e.dz ? 64'(0) : 64'(W + 1));
        check({e.tag, "_busy_cycles"}, 64'(busy_n), e.dz ? 64'(0) : 64'(W + 1));
        mhi = e.hi;
        mlo = e.lo;
        if (!b2b) begin
            @(negedge clk);
            check({e.tag, "_done_pulse"}, 64'(done), 64'(0));
            check({e.tag, "_dz_pulse"}, 64'(div_zero), 64'(0));
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edz, input bit b2b);
        launch(tag, o, x, y, ehi, elo, edz);
        wait_done(b2b);
    endtask

    // MTHI then MTLO.
    task automatic mt(input logic [W-1:0] hv, input logic [W-1:0] lv);
        hi_w = 1'b1; wdata = hv;
        @(negedge clk);
        hi_w = 1'b0; lo_w = 1'b1; wdata = lv;
        @(negedge clk);
        lo_w = 1'b0;
        check("mthi", 64'(hi), 64'(hv));
        check("mtlo", 64'(lo), 64'(lv));
        mhi = hv;
        mlo = lv;
    endtask

    // Count done pulses over a window while idle.
    task automatic quiet(input string tag, input int cycles);
        int nd = 0;
        int nb = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done === 1'b1) nd++;
            if (busy === 1'b1) nb++;
            @(negedge clk);
        end
        check({tag, "_no_done"}, 64'(nd), 64'(0));
        check({tag, "_no_busy"}, 64'(nb), 64'(0));
    endtask

    initial begin
        int nd;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dz", 64'(div_zero), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic directed cases
        run_op("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
        run_op("divu",      3'b011, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0);
        run_op("div_neg_a", 3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("div_neg_b", 3'b010, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 1'b0);
        run_op("mult_nn",   3'b000, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0,         32'd30,        1'b0, 1'b0);
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         1'b0, 1'b0);

        // Divide by zero leaves preloaded HI/LO
        mt(32'h11, 32'h22);
        run_op("div_zero",  3'b010, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1'b0);

        // Back-to-back: second start in the cycle done is high
        run_op("b2b_first",  3'b001, 32'd3,         32'd5, 32'd0,         32'd15,        1'b0, 1'b1);
        run_op("b2b_second", 3'b010, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 1'b0);

        // Start and MTHI ignored while busy, then cancel
        op = 3'b001; a = 32'h1234_5678; b = 32'h0000_9ABC; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int k = 0; k <= 10; k++) begin
            if (done === 1'b1) nd++;
            if (k == 8) check("cancel_busy_mid", 64'(busy), 64'(1));
            if (k == 5) begin
                start = 1'b1; op = 3'b011; a = 32'd1; b = 32'd1;
                hi_w = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (k == 6) begin
                start = 1'b0; hi_w = 1'b0;
            end
            if (k == 10) cancel = 1'b1;
            @(negedge clk);
        end
        cancel = 1'b0;
        check("cancel_busy_low", 64'(busy), 64'(0));
        check("cancel_no_done", 64'(nd), 64'(0));
        check("cancel_hi", 64'(hi), 64'(mhi));
        check("cancel_lo", 64'(lo), 64'(mlo));
        quiet("after_cancel", 40);
        check("after_cancel_hi", 64'(hi), 64'(mhi));

        // Asynchronous reset in the middle of a DIVU
        op = 3'b011; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("async_rst_hi", 64'(hi), 64'(0));
        check("async_rst_lo", 64'(lo), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_done", 64'(done), 64'(0));
        check("async_rst_dz", 64'(div_zero), 64'(0));
        mhi = '0; mlo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("multu_after_rst", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);

        // Same-cycle MTLO and start: write lands, result later overwrites
        lo_w = 1'b1; wdata = 32'h55;
        launch("wr_and_start", 3'b001, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        lo_w = 1'b0;
        check("wr_and_start_lo_early", 64'(lo), 64'(32'h55));
        wait_done(1'b0);

        // Cancel in IDLE blocks a same-cycle start
        op = 3'b001; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        quiet("idle_cancel", 40);
        check("idle_cancel_lo", 64'(lo), 64'(mlo));

        // MADDU (accumulates only when the feature is built in)
        mt(32'd0, 32'h10);
`ifdef MULDIV_MADD_EN
        run_op("maddu", 3'b101, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'h0000_000E, 1'b0, 1'b0);
`else
        run_op("maddu", 3'b101, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0);
`endif

        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
